// File: rtl/prime_nth_engine.sv
// Nth-prime engine: trial division by odd divisors using a bit-serial restoring remainder unit.
// Optional cycle counter output cycles_out is enabled by defining PRIME_CYCLE_COUNT_EN.
module prime_nth_engine #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_WIDTH = 16
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n_in,
    output logic               busy,
    output logic               done,
    output logic               result_valid,
    output logic [WIDTH-1:0]   result,
    output logic               error
`ifdef PRIME_CYCLE_COUNT_EN
    ,
    output logic [31:0]        cycles_out
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INIT      = 3'd1;
    localparam logic [2:0] S_NEXT_CAND = 3'd2;
    localparam logic [2:0] S_DIV_INIT  = 3'd3;
    localparam logic [2:0] S_DIV_RUN   = 3'd4;
    localparam logic [2:0] S_CHECK     = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    localparam int unsigned    BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0]  LAST_BIT = BW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CAND_MAX = {WIDTH{1'b1}} - WIDTH'(2);

    logic [2:0]           state_q, state_d;
    logic [N_WIDTH-1:0]   n_q, n_d;
    logic [N_WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]     cand_q, cand_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic [2*WIDTH-1:0]   dsq_q, dsq_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rv_q, rv_d;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 fin;

    logic [WIDTH:0]       shifted, trial;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     d_next;
    logic [2*WIDTH-1:0]   dsq_next;
    logic [2*WIDTH-1:0]   cand_ext;

    // One restoring step: a borrow out of the top bit means the trial subtraction went negative.
    assign shifted  = {rem_q, dvd_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, d_q};
    assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign d_next   = d_q + WIDTH'(2);
    assign dsq_next = dsq_q + {{(WIDTH-2){1'b0}}, d_q, 2'b00} + (2*WIDTH)'(4);
    assign cand_ext = {{WIDTH{1'b0}}, cand_q};

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        count_d  = count_q;
        cand_d   = cand_q;
        d_d      = d_q;
        dsq_d    = dsq_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        bit_d    = bit_q;
        busy_d   = busy_q;
        rv_d     = rv_q;
        err_d    = err_q;
        result_d = result_q;
        fin      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_in;
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (n_q == '0) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    fin      = 1'b1;
                end else if (n_q == N_WIDTH'(1)) begin
                    result_d = WIDTH'(2);
                    fin      = 1'b1;
                end else begin
                    count_d = N_WIDTH'(1);
                    cand_d  = WIDTH'(3);
                    state_d = S_DIV_INIT;
                end
            end
            S_DIV_INIT: begin
                d_d   = WIDTH'(3);
                dsq_d = (2*WIDTH)'(9);
                if ((2*WIDTH)'(9) > cand_ext) begin
                    state_d = S_CHECK;
                end else begin
                    rem_d   = '0;
                    dvd_d   = cand_q;
                    bit_d   = '0;
                    state_d = S_DIV_RUN;
                end
            end
            S_DIV_RUN: begin
                rem_d = rem_next;
                dvd_d = dvd_q << 1;
                bit_d = bit_q + BW'(1);
                if (bit_q == LAST_BIT) begin
                    if (rem_next == '0) begin
                        state_d = S_NEXT_CAND;
                    end else begin
                        d_d   = d_next;
                        dsq_d = dsq_next;
                        if (dsq_next > cand_ext) begin
                            state_d = S_CHECK;
                        end else begin
                            // Reload immediately so every division stays exactly WIDTH cycles.
                            rem_d = '0;
                            dvd_d = cand_q;
                            bit_d = '0;
                        end
                    end
                end
            end
            S_CHECK: begin
                count_d = count_q + N_WIDTH'(1);
                if (count_d == n_q) begin
                    result_d = cand_q;
                    fin      = 1'b1;
                end else begin
                    state_d = S_NEXT_CAND;
                end
            end
            S_NEXT_CAND: begin
                if (cand_q > CAND_MAX) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    fin      = 1'b1;
                end else begin
                    cand_d  = cand_q + WIDTH'(2);
                    state_d = S_DIV_INIT;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            rv_d    = 1'b1;
            state_d = S_FINISH;
        end
        done_d = fin;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            count_q  <= '0;
            cand_q   <= '0;
            d_q      <= '0;
            dsq_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            bit_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            count_q  <= count_d;
            cand_q   <= cand_d;
            d_q      <= d_d;
            dsq_q    <= dsq_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            bit_q    <= bit_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = rv_q;
    assign result       = result_q;
    assign error        = err_q;

`ifdef PRIME_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] cycles_q, cycles_d;

    // cyc_q holds the 1-based index of the current cycle, counting the start cycle as 1.
    always_comb begin
        cyc_d    = cyc_q;
        cycles_d = cycles_q;
        if (state_q == S_IDLE && start) begin
            cyc_d = 32'd2;
        end else if (busy_q && state_q != S_FINISH && cyc_q != '1) begin
            cyc_d = cyc_q + 32'd1;
        end
        if (fin) begin
            cycles_d = (cyc_q == '1) ? '1 : cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            cyc_q    <= '0;
            cycles_q <= '0;
        end else begin
            cyc_q    <= cyc_d;
            cycles_q <= cycles_d;
        end
    end

    assign cycles_out = cycles_q;
`endif

endmodule
